vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and the default 640x480@60 timing constants.
package vga_pkg;

   // One axis worth of timing: visible span followed by front porch, sync, back porch.
   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
   localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

   localparam int unsigned DEF_CLK_DIV = 2;
   localparam int unsigned DEF_CW      = 10;
   localparam int unsigned DEF_FCW     = 8;

   // Full period of one axis in units of that axis (pixels or lines).
   function automatic int unsigned timing_total(vga_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing outputs bundled for the generator (master) and its consumers (slave).
interface vga_timing_gen_if #(
   parameter int unsigned CW  = 10,
   parameter int unsigned FCW = 8
);
   logic           pix_en_o;
   logic [CW-1:0]  drawx_o;
   logic [CW-1:0]  drawy_o;
   logic           hs_o;
   logic           vs_o;
   logic           de_o;
   logic           blank_o;
   logic           line_start_o;
   logic           frame_start_o;
   logic           vblank_o;
   logic [FCW-1:0] frame_cnt_o;

   modport master (
      output pix_en_o, drawx_o, drawy_o, hs_o, vs_o, de_o, blank_o,
             line_start_o, frame_start_o, vblank_o, frame_cnt_o
   );

   modport slave (
      input  pix_en_o, drawx_o, drawy_o, hs_o, vs_o, de_o, blank_o,
             line_start_o, frame_start_o, vblank_o, frame_cnt_o
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus registered active/sync flags that
// always describe the count currently presented.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = VGA_640X480_H.active,
   parameter int unsigned FP     = VGA_640X480_H.fp,
   parameter int unsigned SYNC   = VGA_640X480_H.sync,
   parameter int unsigned BP     = VGA_640X480_H.bp,
   parameter bit          POL    = 1'b0,
   parameter int unsigned CW     = DEF_CW
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          advance_i,
   output logic [CW-1:0] count_o,
   output logic          wrap_o,
   output logic          active_o,
   output logic          sync_o
);

   localparam vga_timing_t   TIM        = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
   localparam int unsigned   TOTAL      = timing_total(TIM);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] count_q, count_d;
   logic          active_q, active_d;
   logic          sync_q, sync_d;

   // Next count and flags are decoded from the next count so they flip on the same edge.
   always_comb begin
      count_d  = count_q;
      active_d = active_q;
      sync_d   = sync_q;
      wrap_o   = advance_i && (count_q == LAST);
      if (advance_i) begin
         count_d  = wrap_o ? '0 : count_q + 1'b1;
         active_d = (count_d < ACT_END);
         sync_d   = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
      end
   end

   // Axis state register; reset presents position 0 (visible, sync idle).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q  <= '0;
         active_q <= 1'b1;
         sync_q   <= ~POL;
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
         sync_q   <= sync_d;
      end
   end

   assign count_o  = count_q;
   assign active_o = active_q;
   assign sync_o   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider driving horizontal and vertical
// axis counters, with line/frame strobes and a wrapping frame counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
   parameter int unsigned H_FP     = VGA_640X480_H.fp,
   parameter int unsigned H_SYNC   = VGA_640X480_H.sync,
   parameter int unsigned H_BP     = VGA_640X480_H.bp,
   parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
   parameter int unsigned V_FP     = VGA_640X480_V.fp,
   parameter int unsigned V_SYNC   = VGA_640X480_V.sync,
   parameter int unsigned V_BP     = VGA_640X480_V.bp,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned FCW      = DEF_FCW
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   vga_timing_gen_if.master  vid
);

   localparam vga_timing_t H_TIM     = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam vga_timing_t V_TIM     = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int unsigned H_TOTAL   = timing_total(H_TIM);
   localparam int unsigned V_TOTAL   = timing_total(V_TIM);
   localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
   localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   if (CW < unsigned'($clog2(MAX_TOTAL))) begin : g_err_cw
      $error("vga_timing_gen: CW too narrow for the line/frame totals");
   end
   if (CLK_DIV < 1) begin : g_err_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
       (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_err_seg
      $error("vga_timing_gen: timing segments must be non-zero");
   end

   logic [DW-1:0]  div_q, div_d;
   logic           pix_en;
   logic [CW-1:0]  x_cnt, y_cnt;
   logic           x_wrap, y_wrap;
   logic           x_active, y_active;
   logic           hs, vs;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

   // Pixel divider: runs only while enabled, strobe on its last count.
   always_comb begin
      div_d  = div_q;
      pix_en = enable_i & ~reset_i & (div_q == DIV_LAST);
      if (enable_i) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   // Divider register.
   always_ff @(posedge clk_i) begin
      if (reset_i) div_q <= '0;
      else         div_q <= div_d;
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h_axis (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .advance_i (pix_en),
      .count_o   (x_cnt),
      .wrap_o    (x_wrap),
      .active_o  (x_active),
      .sync_o    (hs)
   );

   // Vertical axis steps only on a line wrap, so vs changes on line boundaries.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v_axis (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .advance_i (x_wrap),
      .count_o   (y_cnt),
      .wrap_o    (y_wrap),
      .active_o  (y_active),
      .sync_o    (vs)
   );

   // Strobes fire on the edge the counters reach x=0 / (0,0); frame count follows.
   always_comb begin
      line_start_d  = x_wrap;
      frame_start_d = x_wrap & y_wrap;
      frame_cnt_d   = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end
   end

   // Strobe and frame counter registers; reset itself never raises a strobe.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign vid.pix_en_o      = pix_en;
   assign vid.drawx_o       = x_cnt;
   assign vid.drawy_o       = y_cnt;
   assign vid.hs_o          = hs;
   assign vid.vs_o          = vs;
   assign vid.de_o          = x_active & y_active;
   assign vid.blank_o       = ~(x_active & y_active);
   assign vid.vblank_o      = ~y_active;
   // Strobes are suppressed while paused.
   assign vid.line_start_o  = line_start_q & enable_i;
   assign vid.frame_start_o = frame_start_q & enable_i;
   assign vid.frame_cnt_o   = frame_cnt_q;

endmodule
